toggle_activity_monitor: RTL

TOGGLE_ACTIVITY_MONITOR -- requirements
Module: toggle_activity_monitor

---
 rtl/thermal_pkg.sv | 22 ++
 rtl/activity_sample_fifo.sv | 63 ++++++
 rtl/toggle_activity_monitor.sv | 127 ++++++++++++
 3 files changed

// File: rtl/thermal_pkg.sv
// Shared definitions for the toggle-activity monitor: FSM encoding, default
// sizing and the field widths of one sample record {win_idx, sum, sat}.
package thermal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_ACCUM = 2'd2
    } mon_state_t;

    localparam int unsigned DEF_WIDTH  = 8;
    localparam int unsigned DEF_WINDOW = 256;
    localparam int unsigned DEF_CNT_W  = 16;

    localparam int unsigned WIN_W = 8;
    localparam int unsigned SAT_W = 1;

    function automatic int unsigned rec_w(input int unsigned cnt_w);
        return cnt_w + WIN_W + SAT_W;
    endfunction

endpackage

// File: rtl/activity_sample_fifo.sv
// Two-entry shift FIFO for sample records; the head always lives in slot 0 so
// the valid flag and head payload come straight from registers.
module activity_sample_fifo #(
    parameter int unsigned REC_W = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [REC_W-1:0] push_rec,
    input  logic             rdy,
    output logic             vld,
    output logic [REC_W-1:0] head,
    output logic             drop_c
);

    logic [REC_W-1:0] mem1_q;
    logic             vld1_q;
    logic             pop_c;
    logic             accept_c;

    // A full FIFO still takes a push when the head leaves on the same edge.
    always_comb begin
        pop_c    = vld & rdy;
        accept_c = push & (~vld1_q | pop_c);
        drop_c   = push & vld1_q & ~pop_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld    <= 1'b0;
            vld1_q <= 1'b0;
            head   <= '0;
            mem1_q <= '0;
        end else begin
            case ({pop_c, accept_c})
                2'b11: begin
                    if (vld1_q) begin
                        head   <= mem1_q;
                        mem1_q <= push_rec;
                    end else begin
                        head   <= push_rec;
                    end
                end
                2'b10: begin
                    head   <= mem1_q;
                    vld    <= vld1_q;
                    vld1_q <= 1'b0;
                end
                2'b01: begin
                    if (!vld) begin
                        head <= push_rec;
                        vld  <= 1'b1;
                    end else begin
                        mem1_q <= push_rec;
                        vld1_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/toggle_activity_monitor.sv
// Counts output toggles on a group of monitored nets over fixed windows and
// hands each window's total to a downstream power model through a small FIFO.
module toggle_activity_monitor
    import thermal_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned WINDOW = DEF_WINDOW,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             EN,
    input  logic [WIDTH-1:0] NET,
    input  logic             RDY,
    output logic             VLD,
    output logic [CNT_W-1:0] SUM,
    output logic [WIN_W-1:0] WIN,
    output logic             SAT,
    output logic             OVF
);

    localparam int unsigned PC_W  = $clog2(WIDTH + 1);
    localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam int unsigned CYC_W = $clog2(WINDOW);
    localparam int unsigned REC_W = rec_w(CNT_W);
    localparam logic [CNT_W-1:0] ACC_MAX = '1;

    mon_state_t       state_q;
    mon_state_t       state_d;
    logic [WIDTH-1:0] net_q;
    logic [CNT_W-1:0] acc_q;
    logic             sat_q;
    logic [CYC_W-1:0] cyc_q;
    logic [WIN_W-1:0] win_idx_q;

    logic             load_c;
    logic             accum_c;
    logic             last_c;
    logic [PC_W-1:0]  pc_c;
    logic [SUM_W-1:0] sum_c;
    logic             clip_c;
    logic [CNT_W-1:0] acc_nxt_c;
    logic             sat_nxt_c;
    logic             push_c;
    logic [REC_W-1:0] push_rec_c;
    logic [REC_W-1:0] head;
    logic             drop_c;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (EN) state_d = ST_PRIME;
            ST_PRIME: state_d = ST_ACCUM;
            ST_ACCUM: state_d = ST_ACCUM;
            default:  state_d = ST_IDLE;
        endcase
        if (!EN) state_d = ST_IDLE;
    end

    always_comb begin
        load_c  = (state_q == ST_PRIME);
        accum_c = (state_q == ST_ACCUM) && EN;
    end

    // Toggle count this cycle, saturating add into the window accumulator.
    always_comb begin
        pc_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            pc_c = pc_c + PC_W'(NET[i] ^ net_q[i]);
        end
        sum_c      = SUM_W'(acc_q) + SUM_W'(pc_c);
        clip_c     = (sum_c > SUM_W'(ACC_MAX));
        acc_nxt_c  = clip_c ? ACC_MAX : sum_c[CNT_W-1:0];
        sat_nxt_c  = sat_q | clip_c;
        last_c     = (cyc_q == CYC_W'(WINDOW - 1));
        push_c     = accum_c & last_c;
        push_rec_c = {win_idx_q, acc_nxt_c, sat_nxt_c};
    end

    // Anything other than an enabled ACCUM cycle throws away the partial window.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            net_q     <= '0;
            acc_q     <= '0;
            sat_q     <= 1'b0;
            cyc_q     <= '0;
            win_idx_q <= '0;
            OVF       <= 1'b0;
        end else begin
            if (load_c || accum_c) net_q <= NET;
            if (accum_c && !last_c) begin
                acc_q <= acc_nxt_c;
                sat_q <= sat_nxt_c;
                cyc_q <= cyc_q + CYC_W'(1);
            end else begin
                acc_q <= '0;
                sat_q <= 1'b0;
                cyc_q <= '0;
            end
            if (push_c) win_idx_q <= win_idx_q + WIN_W'(1);
            if (drop_c) OVF <= 1'b1;
        end
    end

    activity_sample_fifo #(
        .REC_W (REC_W)
    ) u_fifo (
        .clk      (CK),
        .rst_n    (RN),
        .push     (push_c),
        .push_rec (push_rec_c),
        .rdy      (RDY),
        .vld      (VLD),
        .head     (head),
        .drop_c   (drop_c)
    );

    assign WIN = head[REC_W-1 -: WIN_W];
    assign SUM = head[CNT_W:1];
    assign SAT = head[0];

endmodule
